// File: rtl/rv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: load width codes, FSM states
// and the context captured while a load is pending.
package rv_writeback_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [2:0] fun;
    logic [4:0] rd;
    logic [1:0] addr;
  } ld_ctx_t;

endpackage

// File: rtl/rv_writeback_load_align.sv
// Combinational load formatter: picks the addressed byte/halfword/word and
// sign- or zero-extends it according to the width code.
module rv_load_align
  import rv_writeback_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] value
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  assign w_byte_sh = data >> {addr, 3'b000};
  assign w_half_sh = data >> {addr[1], 4'b0000};

  always_comb begin
    value = 32'd0;
    case (fun)
      LDST_B:  value = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      LDST_BU: value = {24'd0, w_byte_sh[7:0]};
      LDST_H:  value = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      LDST_HU: value = {16'd0, w_half_sh[15:0]};
      LDST_L:  value = data;
      default: value = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv_writeback.sv
// uRV writeback stage: registers ALU results into the register file port and
// waits for, formats and writes load data, with a stall request and timeout.
module rv_writeback
  import rv_writeback_pkg::*;
#(
  parameter int unsigned G_LOAD_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_req_o,
  output logic        w_load_err_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o
);

  localparam int unsigned LIMIT = G_LOAD_TIMEOUT - 1;

  wb_state_t        r_state, w_state_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  ld_ctx_t          r_ctx, w_ctx_nx;
  logic [4:0]       w_rd_nx;
  logic [31:0]      w_val_nx;
  logic             w_we_nx;
  logic             w_err_nx;
  logic             w_limit;
  logic [2:0]       w_sel_fun;
  logic [1:0]       w_sel_addr;
  logic [31:0]      w_aligned;
  logic             w_unused;

  assign w_unused = &{1'b0, x_dm_addr_i[31:2]};

  // The timeout fires on the wait cycle whose incremented count would reach the limit.
  assign w_limit = (9'(r_count) + 9'd1) >= 9'(LIMIT);

  assign w_sel_fun  = (r_state == WB_LOAD_WAIT) ? r_ctx.fun  : x_fun_i;
  assign w_sel_addr = (r_state == WB_LOAD_WAIT) ? r_ctx.addr : x_dm_addr_i[1:0];

  rv_load_align u_align (
    .fun   (w_sel_fun),
    .addr  (w_sel_addr),
    .data  (dm_data_l_i),
    .value (w_aligned)
  );

  // Next-state, stall and register-file write decisions.
  always_comb begin
    w_state_nx    = r_state;
    w_count_nx    = r_count;
    w_ctx_nx      = r_ctx;
    w_rd_nx       = rf_rd_o;
    w_val_nx      = rf_rd_value_o;
    w_we_nx       = 1'b0;
    w_err_nx      = 1'b0;
    w_stall_req_o = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (!x_load_i) begin
          w_rd_nx  = x_rd_i;
          w_val_nx = x_rd_value_i;
          w_we_nx  = x_rd_write_i && (x_rd_i != 5'd0);
        end else if (dm_load_done_i) begin
          w_rd_nx  = x_rd_i;
          w_val_nx = w_aligned;
          w_we_nx  = (x_rd_i != 5'd0);
        end else begin
          w_stall_req_o = 1'b1;
          w_ctx_nx      = '{fun: x_fun_i, rd: x_rd_i, addr: x_dm_addr_i[1:0]};
          w_count_nx    = '0;
          w_state_nx    = WB_LOAD_WAIT;
        end
      end
      WB_LOAD_WAIT: begin
        w_stall_req_o = !dm_load_done_i;
        if (dm_load_done_i) begin
          w_rd_nx    = r_ctx.rd;
          w_val_nx   = w_aligned;
          w_we_nx    = (r_ctx.rd != 5'd0);
          w_state_nx = WB_IDLE;
        end else if (w_limit) begin
          w_err_nx   = 1'b1;
          w_count_nx = '0;
          w_state_nx = WB_IDLE;
        end else begin
          w_count_nx = r_count + CNT_W'(1);
        end
      end
      default: w_state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= WB_IDLE;
      r_count       <= '0;
      r_ctx         <= '0;
      rf_rd_o       <= 5'd0;
      rf_rd_value_o <= 32'd0;
      rf_rd_write_o <= 1'b0;
      w_load_err_o  <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_count       <= w_count_nx;
      r_ctx         <= w_ctx_nx;
      rf_rd_o       <= w_rd_nx;
      rf_rd_value_o <= w_val_nx;
      rf_rd_write_o <= w_we_nx;
      w_load_err_o  <= w_err_nx;
    end
  end

endmodule

// File: tb/tb_rv_writeback.sv
// Randomized scoreboard bench for rv_writeback with a high-level reference model.
module tb_rv_writeback;

  localparam int unsigned TMO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  x_fun_i;
  logic        x_load_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic [31:0] x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        w_stall_req_o;
  logic        w_load_err_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;

  rv_writeback #(.G_LOAD_TIMEOUT(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .x_fun_i        (x_fun_i),
    .x_load_i       (x_load_i),
    .x_rd_i         (x_rd_i),
    .x_rd_value_i   (x_rd_value_i),
    .x_rd_write_i   (x_rd_write_i),
    .x_dm_addr_i    (x_dm_addr_i),
    .dm_data_l_i    (dm_data_l_i),
    .dm_load_done_i (dm_load_done_i),
    .w_stall_req_o  (w_stall_req_o),
    .w_load_err_o   (w_load_err_o),
    .rf_rd_o        (rf_rd_o),
    .rf_rd_value_o  (rf_rd_value_o),
    .rf_rd_write_o  (rf_rd_write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          err;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference formatting from byte/halfword arithmetic.
  function automatic logic [31:0] model_fmt(input logic [2:0] fun, input logic [1:0] a,
                                            input logic [31:0] d);
    int unsigned b, h;
    b = (d >> (8 * int'(a))) % 256;
    h = (d >> (16 * (int'(a) / 2))) % 65536;
    case (fun)
      3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd5:    return 32'(h);
      3'd2:    return d;
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every write or error pulse must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && (rf_rd_write_o || w_load_err_o)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: we=%b err=%b rd=%0d val=%h at %0t",
                 rf_rd_write_o, w_load_err_o, rf_rd_o, rf_rd_value_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("err_pulse", 32'(w_load_err_o), 32'(e.err));
        chk("rf_write", 32'(rf_rd_write_o), 32'(!e.err));
        if (!e.err) begin
          chk("rf_rd", 32'(rf_rd_o), 32'(e.rd));
          chk("rf_value", rf_rd_value_o, e.val);
        end
      end
    end
  end

  task automatic idle_inputs();
    x_load_i       = 1'b0;
    x_rd_write_i   = 1'b0;
    dm_load_done_i = 1'b0;
  endtask

  task automatic do_nonload(input logic [4:0] rd, input logic [31:0] val, input logic we);
    x_load_i       = 1'b0;
    x_rd_i         = rd;
    x_rd_value_i   = val;
    x_rd_write_i   = we;
    x_fun_i        = 3'($urandom);
    x_dm_addr_i    = $urandom;
    dm_load_done_i = 1'($urandom);
    dm_data_l_i    = $urandom;
    @(negedge clk_i);
    chk("stall_nonload", 32'(w_stall_req_o), 32'd0);
    @(posedge clk_i);
    #1;
    if (we && rd != 5'd0) exp_q.push_back('{err: 1'b0, rd: rd, val: val});
    idle_inputs();
  endtask

  // Load with d not-done cycles before completion; d >= TMO never completes.
  task automatic do_load(input logic [2:0] fun, input logic [4:0] rd, input logic [1:0] a,
                         input logic [31:0] data, input int d);
    int n_stall = 0;
    x_load_i     = 1'b1;
    x_fun_i      = fun;
    x_rd_i       = rd;
    x_dm_addr_i  = {$urandom_range(0, 32'h3fff_ffff), 2'b00} | 32'(a);
    x_rd_value_i = $urandom;
    x_rd_write_i = 1'($urandom);
    for (int c = 0; c <= d && c < int'(TMO); c++) begin
      if (c > 0) begin
        x_load_i     = 1'($urandom);
        x_fun_i      = 3'($urandom);
        x_rd_i       = 5'($urandom);
        x_dm_addr_i  = $urandom;
        x_rd_value_i = $urandom;
      end
      dm_load_done_i = (c == d);
      dm_data_l_i    = (c == d) ? data : $urandom;
      @(negedge clk_i);
      if (w_stall_req_o) n_stall++;
      @(posedge clk_i);
      #1;
    end
    if (d < int'(TMO)) begin
      if (rd != 5'd0) exp_q.push_back('{err: 1'b0, rd: rd, val: model_fmt(fun, a, data)});
    end else begin
      exp_q.push_back('{err: 1'b1, rd: 5'd0, val: 32'd0});
    end
    chk("stall_cycles", 32'(n_stall), 32'((d < int'(TMO)) ? d : int'(TMO)));
    idle_inputs();
  endtask

  initial begin
    rst_i        = 1'b1;
    x_fun_i      = 3'd0;
    x_rd_i       = 5'd0;
    x_rd_value_i = 32'd0;
    x_dm_addr_i  = 32'd0;
    dm_data_l_i  = 32'd0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_rd", 32'(rf_rd_o), 32'd0);
    chk("reset_value", rf_rd_value_o, 32'd0);
    chk("reset_we", 32'(rf_rd_write_o), 32'd0);
    chk("reset_err", 32'(w_load_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    do_nonload(5'd5, 32'h1234_5678, 1'b1);
    do_nonload(5'd0, 32'h1234_5678, 1'b1);
    do_load(3'b000, 5'd1, 2'd3, 32'h80FF_7F01, 0);
    do_load(3'b100, 5'd2, 2'd2, 32'h80FF_7F01, 0);
    do_load(3'b001, 5'd3, 2'd0, 32'h80FF_7F01, 0);
    do_load(3'b101, 5'd4, 2'd2, 32'h80FF_7F01, 0);
    do_load(3'b010, 5'd7, 2'd0, 32'hDEAD_BEEF, 3);
    do_load(3'b010, 5'd9, 2'd1, 32'h1111_2222, 10);
    do_load(3'b010, 5'd0, 2'd0, 32'h5555_AAAA, 2);
    do_load(3'b011, 5'd6, 2'd1, 32'hFFFF_FFFF, 1);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_nonload(5'($urandom), $urandom, 1'($urandom));
      else
        do_load(3'($urandom), 5'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 6)));
    end

    // Reset while a load is pending discards it.
    do_nonload(5'd31, 32'hCAFE_F00D, 1'b1);
    x_load_i       = 1'b1;
    x_fun_i        = 3'b010;
    x_rd_i         = 5'd3;
    dm_load_done_i = 1'b0;
    @(posedge clk_i);
    #1;
    x_load_i = 1'b0;
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("midreset_rd", 32'(rf_rd_o), 32'd0);
    chk("midreset_value", rf_rd_value_o, 32'd0);
    chk("midreset_we", 32'(rf_rd_write_o), 32'd0);
    chk("midreset_stall", 32'(w_stall_req_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    dm_load_done_i = 1'b1;
    dm_data_l_i    = 32'h0BAD_0BAD;
    x_rd_i         = 5'd3;
    x_rd_write_i   = 1'b0;
    @(posedge clk_i);
    #1;
    idle_inputs();
    do_nonload(5'd12, 32'hA5A5_0001, 1'b1);

    repeat (3) @(posedge clk_i);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
